stage_sequencer: RTL
====================

# stage_sequencer

Registered multi-stage sequencer that drives the one-hot stage enables and thermometer progress LEDs of the staged datapath. Runs either automatically, using a per-stage minimum dwell plus a stage-done handshake, or manually, advancing one stage per operator step edge. Break-before-make gaps keep two stage enables from ever being high together. Sits between the operator inputs (switches/buttons) and the stage enable lines, and replaces ad-hoc combinational sequencing.

## Interface
- `NSTAGE`, 4: number of sequenced stages (2..8)
- `DWELL_W`, 8: width of the dwell setting
- `TIMEOUT`, 1023: auto-mode watchdog limit in cycles per stage
- `clk` in 1: single clock, rising edge
- `rst` in 1: **reset is asynchronous and active-low**; all state and outputs clear while low
- `start` in 1: run request, level-sampled
- `mode` in 1: 0 = auto, 1 = manual; latched when `start` is accepted
- `step` in 1: manual advance; rising edge detected internally
- `abort` in 1: cancel the run
- `dwell` in `DWELL_W`: auto minimum cycles per stage; latched at start
- `stage_done` in `NSTAGE`: per-stage completion, level
- `en` out `NSTAGE`: one-hot stage enable, or zero
- `led` out `NSTAGE`: thermometer progress
- `busy` out 1: high in RUN and GAP
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky watchdog error

## Operation
- States: IDLE, RUN, GAP, FINISH, ERR.
- Index `k` selects the active stage. Dwell counter `cnt` is cleared to 1 when RUN is entered.
- **IDLE**
  - `en`=0, `busy`=0; `led` holds its last value.
  - `start`=1 → RUN with k=0; latch `mode` and `dwell`; clear `led` and `err`.
  - A latched `dwell` of 0 is treated as 1.
- **RUN**
  - `en`=1<<k; `led[k:0]`=1.
  - Auto advance: `cnt`≥dwell && `stage_done[k]`.
  - Manual advance: a `step` rising edge; `stage_done` is ignored.
  - On advance: go to GAP if k<NSTAGE-1, otherwise to FINISH.
  - `cnt` increments each cycle and saturates.
- **GAP**: `en`=0 for exactly one cycle; then k←k+1 and go to RUN.
- **FINISH**: `en`=0, `led` all ones, `done`=1 for this one cycle; then go to IDLE.
- **ERR**
  - `en`=0, `err`=1, `led` frozen.
  - `start` → RUN with k=0 and `err` cleared; `abort` → IDLE with `err` kept.
- `abort` in RUN or GAP → IDLE next cycle: `en`=0, `led` cleared, no `done`.
- Abort takes priority over an advance or timeout in the same cycle.
- `start` while busy is ignored. Changes on `mode` or `dwell` mid-run are ignored.
- Edge detector register resets to 0 and tracks `step` in every state, so a step held high when the run starts does not advance.

## Timing
- All outputs are registered. Reset values: `en`=0, `led`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Timeline, with `start` sampled at edge 0:
  - `en[0]` high from cycle 1.
  - Auto mode with `stage_done` held high: stage k occupies D cycles, followed by a 1-cycle gap.
  - `done` is high in cycle NSTAGE·D+NSTAGE. For NSTAGE=4, D=3 this is cycle 16.
- Manual mode: `en[k]` drops on the cycle after the edge that samples the step rise.
- A 1-cycle `stage_done` pulse before `cnt` reaches the dwell is not remembered; it must still be high when the dwell is met.
- Reset asserted mid-run: `en` is forced to 0 immediately (asynchronous), with no `done` pulse.

## Configuration
- `STAGE_TIMEOUT_EN` defined:
  - In auto RUN, a watchdog counts cycles spent in the current stage.
  - Reaching `TIMEOUT` without an advance → ERR next cycle.
  - Manual mode is never timed out.
- `STAGE_TIMEOUT_EN` undefined: no watchdog logic; `err` is tied 0; auto mode waits indefinitely for `stage_done`.

## Structure
- Package `stage_pkg`: state enum `seq_state_t` (IDLE, RUN, GAP, FINISH, ERR), default `NSTAGE`, and the thermometer/one-hot helper functions.
- One sub-module, `edge_rise`: registered rising-edge detector for `step`, with asynchronous active-low reset.

## Test plan
- Auto, D=3, `stage_done`=4'hF: `en` runs 1,0,2,0,4,0,8; `done` in cycle 16; `led` ends at 4'hF; `en` never has two bits set.
- Auto, D=2, `stage_done[1]` raised 10 cycles after `en[1]` rises: `en[1]` stays high until that cycle, then a 1-cycle gap follows.
- Manual, `step` held high at start, then 3 clean pulses: the held level gives no advance; each pulse advances one stage; `stage_done` is ignored.
- `abort` in the same cycle as an auto advance during stage 2: IDLE next cycle, `en`=0, `led`=0, no `done`.
- With `STAGE_TIMEOUT_EN`, `TIMEOUT`=20, auto, `stage_done`=0: ERR after 20 cycles in stage 0 with `err`=1; a new `start` clears `err` and restarts at stage 0.
- `rst` pulsed low in mid-run stage 1: all outputs 0 asynchronously; after release, state is IDLE and a new `start` begins at stage 0.

Source files
------------

// File: rtl/stage_pkg.sv
// stage_pkg: shared types and helpers for the stage sequencer.
// Holds the sequencer state enum, the default stage count and the
// one-hot / thermometer helpers used to build the stage enables and LEDs.
package stage_pkg;

  localparam int DEF_NSTAGE = 4;
  localparam int MAX_NSTAGE = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    FINISH,
    ERR
  } seq_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [MAX_NSTAGE-1:0] stage_onehot(input logic [2:0] idx);
    return MAX_NSTAGE'(1) << idx;
  endfunction

  // Thermometer vector with bits idx down to 0 set.
  function automatic logic [MAX_NSTAGE-1:0] stage_therm(input logic [2:0] idx);
    return (MAX_NSTAGE'(2) << idx) - MAX_NSTAGE'(1);
  endfunction

endpackage

// File: rtl/stage_sequencer_edge_rise.sv
// edge_rise: rising-edge detector for an operator input.
// The previous level is registered; rise is high while sig is high but was
// still low at the last clock edge, so a held level produces no pulse.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Track the input level every cycle, regardless of what the sequencer is doing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: drives one-hot stage enables and thermometer progress LEDs.
// Auto mode advances when the per-stage minimum dwell has elapsed and the
// stage reports done; manual mode advances on each rising edge of step.
// A one-cycle gap with no enable separates consecutive stages.
// Optional feature: define STAGE_TIMEOUT_EN to add a per-stage watchdog in
// auto mode that moves the sequencer to ERR and raises a sticky err flag.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int NSTAGE  = DEF_NSTAGE,
  parameter int DWELL_W = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               step,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NSTAGE-1:0]  stage_done,
  output logic [NSTAGE-1:0]  en,
  output logic [NSTAGE-1:0]  led,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int K_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NSTAGE - 1);
  localparam logic [DWELL_W-1:0] CNT_MAX = '1;

  seq_state_t         state;
  logic [K_W-1:0]     k;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q;
  logic               step_rise;
  logic               advance;

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = '1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] wd;
`endif

  edge_rise u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (step),
    .rise (step_rise)
  );

  // Advance request for the active stage: step edge in manual, dwell met plus stage_done in auto.
  always_comb begin
    advance = 1'b0;
    if (mode_q) begin
      advance = step_rise;
    end else begin
      advance = (cnt >= dwell_q) && stage_done[k];
    end
  end

  // Sequencer state machine; every output is registered here alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      en      <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
      wd      <= '0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            k       <= '0;
            cnt     <= DWELL_W'(1);
            mode_q  <= mode;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            en      <= NSTAGE'(stage_onehot(3'(0)));
            led     <= NSTAGE'(stage_therm(3'(0)));
            busy    <= 1'b1;
`ifdef STAGE_TIMEOUT_EN
            wd      <= WD_W'(1);
            err     <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + DWELL_W'(1);
          end
`ifdef STAGE_TIMEOUT_EN
          if (wd != WD_MAX) begin
            wd <= wd + WD_W'(1);
          end
`endif
          if (abort) begin
            state <= IDLE;
            en    <= '0;
            led   <= '0;
            busy  <= 1'b0;
          end else if (advance) begin
            en <= '0;
            if (k == K_LAST) begin
              state <= FINISH;
              led   <= '1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
`ifdef STAGE_TIMEOUT_EN
          else if (!mode_q && (wd >= WD_LIMIT)) begin
            state <= ERR;
            en    <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
`endif
        end

        GAP: begin
          if (abort) begin
            state <= IDLE;
            en    <= '0;
            led   <= '0;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
            k     <= k + K_W'(1);
            cnt   <= DWELL_W'(1);
            en    <= NSTAGE'(stage_onehot(3'(k + K_W'(1))));
            led   <= NSTAGE'(stage_therm(3'(k + K_W'(1))));
`ifdef STAGE_TIMEOUT_EN
            wd    <= WD_W'(1);
`endif
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        ERR: begin
          if (start) begin
            state   <= RUN;
            k       <= '0;
            cnt     <= DWELL_W'(1);
            mode_q  <= mode;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            en      <= NSTAGE'(stage_onehot(3'(0)));
            led     <= NSTAGE'(stage_therm(3'(0)));
            busy    <= 1'b1;
`ifdef STAGE_TIMEOUT_EN
            wd      <= WD_W'(1);
            err     <= 1'b0;
`endif
          end else if (abort) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          en    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef STAGE_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule
